// File: rtl/dcache_wb_direct.sv
// ----------------------------------------------------------------------------
// dcache_wb_direct
//
// Direct-mapped, write-back, write-allocate data cache that sits between the
// CPU memory-access stage and main data memory. The cache handles 32-bit words
// only. Misses are serviced by whole-block transfers with main memory.
//
// Parameters:
//   BLOCKS         number of cache lines (power of 2, >= 2)
//
// Ports:
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   READ, WRITE    CPU word read / write request (WRITE wins if both are set)
//   ADDRESS        CPU byte address: [3:2] word, [IDX+3:4] index, upper bits tag
//   WRITEDATA      CPU store data
//   READDATA       CPU load data (live from the array on a read hit, else held)
//   BUSYWAIT       stalls the CPU pipeline
//   MEM_READ       main memory block read strobe
//   MEM_WRITE      main memory block write strobe
//   MEM_ADDRESS    block address (byte address >> 4)
//   MEM_WRITEDATA  evicted block, word0 in [31:0]
//   MEM_READDATA   fetched block, word0 in [31:0]
//   MEM_BUSYWAIT   main memory busy
//
// Build option DCACHE_STATS_EN adds saturating 32-bit HIT_COUNT / MISS_COUNT
// outputs.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | serve hits with zero stall, detect misses
// WRITEBACK  | write the dirty victim line to memory
// ALLOCATE   | read the requested block from memory
// UPDATE     | install the fetched block, then return to IDLE to re-hit
// ----------------------------------------------------------------------------
module dcache_wb_direct #(
  parameter int BLOCKS = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int WORDS  = 4;
  localparam int LINE_W = 32 * WORDS;
  localparam int IDX_W  = $clog2(BLOCKS);
  localparam int TAG_W  = 28 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Address fields
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       woff;
  logic             unused_addr_lsb;

  assign idx  = ADDRESS[IDX_W+3:4];
  assign tag  = ADDRESS[31:IDX_W+4];
  assign woff = ADDRESS[3:2];
  assign unused_addr_lsb = ^ADDRESS[1:0];

  // Line storage
  logic [LINE_W-1:0] data_q [BLOCKS];
  logic [TAG_W-1:0]  tag_q  [BLOCKS];
  logic [BLOCKS-1:0] valid_q;
  logic [BLOCKS-1:0] dirty_q;

  logic [31:0] rdata_q, rdata_d;

  logic              req;
  logic              in_idle;
  logic              hit;
  logic              rd_hit;
  logic              wr_hit;
  logic              miss;
  logic              victim_dirty;
  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] line_wr;
  logic [31:0]       cur_word;

  assign req          = READ | WRITE;
  assign in_idle      = (state_q == S_IDLE);
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_hit       = in_idle && READ && !WRITE && hit;
  assign wr_hit       = in_idle && WRITE && hit;
  assign miss         = in_idle && req && !hit;
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  always_comb begin
    cur_line = data_q[idx];
    cur_word = cur_line[{woff, 5'b0} +: 32];
    line_wr  = cur_line;
    line_wr[{woff, 5'b0} +: 32] = WRITEDATA;
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss) state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
      end
      S_WRITEBACK: begin
        if (!MEM_BUSYWAIT) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      S_IDLE: begin
        BUSYWAIT = miss;
      end
      S_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = cur_line;
      end
      S_ALLOCATE: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, idx};
      end
      S_UPDATE: begin
        BUSYWAIT = 1'b1;
      end
      default: BUSYWAIT = 1'b0;
    endcase
  end

  // Read data is live from the array on a hit and held otherwise, so the
  // register simply tracks whatever was last presented.
  assign rdata_d  = rd_hit ? cur_word : rdata_q;
  assign READDATA = rdata_d;

  always_ff @(posedge CLK) begin
    if (RESET) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == S_UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Data and tags need no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == S_UPDATE) begin
        data_q[idx] <= MEM_READDATA;
        tag_q[idx]  <= tag;
      end else if (wr_hit) begin
        data_q[idx] <= line_wr;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  // Set while a miss is being serviced so the re-hit after UPDATE is not
  // counted as a fresh hit.
  logic        refill_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      if (miss) begin
        refill_q <= 1'b1;
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end else if (in_idle && req && hit) begin
        refill_q <= 1'b0;
        if (!refill_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_wb_direct.md
Name: dcache_wb_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU memory-access stage and main data memory.
- Consumes the CPU's `READ`/`WRITE`/`M_ADDRESS`/`M_WRITEDATA` and returns `M_READDATA`/`M_BUSYWAIT`.
- Byte/half handling stays in the CPU read/write controllers; the cache handles word accesses only.
- Misses are serviced by a block-wide handshake with main memory.

Parameters:
- `BLOCKS`, 8, number of cache lines; power of 2, ≥2.
- `WORDS`, 4, fixed 32-bit words per line (16-byte block); not overridable.

Ports:
- `CLK`  in  1  system clock
- `RESET`  in  1  synchronous, active-high reset
- `READ`  in  1  CPU word read request
- `WRITE`  in  1  CPU word write request
- `ADDRESS`  in  32  CPU byte address; [1:0] ignored, [3:2] word offset, [log2(BLOCKS)+3:4] index, upper bits tag
- `WRITEDATA`  in  32  CPU store data
- `READDATA`  out  32  CPU load data
- `BUSYWAIT`  out  1  stall CPU pipeline
- `MEM_READ`  out  1  main memory block read
- `MEM_WRITE`  out  1  main memory block write
- `MEM_ADDRESS`  out  28  block address (byte address >> 4)
- `MEM_WRITEDATA`  out  128  evicted block, word0 in [31:0]
- `MEM_READDATA`  in  128  fetched block, word0 in [31:0]
- `MEM_BUSYWAIT`  in  1  main memory busy

Behaviour:
- Reset (synchronous, `RESET`=1 at posedge): all valid=0, dirty=0, state=IDLE, `BUSYWAIT`=0, `MEM_READ`=0, `MEM_WRITE`=0, `MEM_ADDRESS`=0, `MEM_WRITEDATA`=0, `READDATA`=0.
- Reset mid-miss: transaction abandoned, line left invalid, memory strobes low after that edge.
- Request = `READ`|`WRITE`. CPU holds `ADDRESS`/`WRITEDATA`/`READ`/`WRITE` stable while `BUSYWAIT`=1. `READ`&`WRITE` together: `WRITE` wins, `READ` ignored.
- Hit = valid[index] & tag match.
- IDLE, read hit: `READDATA` = selected word, combinational from array; `BUSYWAIT`=0 in the same cycle (zero-stall).
- IDLE, write hit: `BUSYWAIT`=0; word written and dirty=1 at the next posedge.
- IDLE, miss: `BUSYWAIT`=1 combinationally in the same cycle. Next state WRITEBACK if valid&dirty, else ALLOCATE.
- WRITEBACK:
  - `MEM_WRITE`=1, `MEM_ADDRESS`={stored tag, index}, `MEM_WRITEDATA`=line.
  - Stay while `MEM_BUSYWAIT`=1; on first cycle with `MEM_BUSYWAIT`=0 after entry, go to ALLOCATE.
- ALLOCATE:
  - `MEM_READ`=1, `MEM_ADDRESS`={`ADDRESS` tag, index}.
  - Stay while `MEM_BUSYWAIT`=1; on its deassertion go to UPDATE.
  - `MEM_READDATA` is sampled in UPDATE.
- UPDATE (one cycle): line←`MEM_READDATA`, tag←new tag, valid=1, dirty=0; `BUSYWAIT`=1; next state IDLE.
  - In IDLE the request now hits, and a write hit sets dirty.
- `BUSYWAIT` deasserts on the IDLE hit cycle following UPDATE.
- Miss cost: clean miss = memory latency + 2 cycles; dirty miss adds the writeback latency.
- Strobes: `MEM_READ` and `MEM_WRITE` are never both 1, and never asserted in IDLE/UPDATE.
- No request in IDLE: `BUSYWAIT`=0, `READDATA` holds its previous value, and no array update occurs.
- `MEM_BUSYWAIT` sampled at posedge only; a memory that responds in the same cycle (busy never asserted) still costs one cycle per memory state.

Optional Feature:
- `DCACHE_STATS_EN` defined: adds outputs `HIT_COUNT[31:0]` and `MISS_COUNT[31:0]`.
  - Cleared on `RESET`.
  - `HIT_COUNT` increments once per hit completed in IDLE from a first-time request; the post-UPDATE re-hit does not count.
  - `MISS_COUNT` increments once per IDLE→WRITEBACK/ALLOCATE transition.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then read 0x00000040, memory block = {0x44,0x33,0x22,0x11} (word0=0x11), 3-cycle memory latency → `MEM_READ` with `MEM_ADDRESS`=0x0000004; `BUSYWAIT` high 5 cycles; `READDATA`=0x11; re-read 0x44 → 0x22 with zero stall.
- Write 0xDEADBEEF to 0x00000048 after the previous fill → no stall; read 0x48 returns 0xDEADBEEF; `MEM_WRITE` never asserted.
- Read 0x000000C0 (same index 4, new tag) with dirty line → `MEM_WRITE` first with `MEM_ADDRESS`=0x0000004 and `MEM_WRITEDATA`[95:64]=0xDEADBEEF, then `MEM_READ` `MEM_ADDRESS`=0x000000C, then hit.
- Assert `RESET` during ALLOCATE → strobes low next cycle, `BUSYWAIT`=0; subsequent read of the same address misses again.
- `READ` and `WRITE` both high to 0x10 with data 0x5 → treated as write; later read 0x10 → 0x5.
- With `DCACHE_STATS_EN`: 4 hits + 2 misses sequence → `HIT_COUNT`=4, `MISS_COUNT`=2.
